// File: rtl/spi_flash_master.sv
// Byte-wide mode-0 SPI master for the configuration flash, mapped as a data and a
// control/status register on the delayed IO bus.
module spi_flash_master #(
    parameter int unsigned DIV       = 2,
    parameter int unsigned XFER_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic        sel_data,
    input  logic        sel_ctrl,
    input  logic [15:0] wd,
    output logic [15:0] rd_data,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [2:0] LAST_BIT = 3'(XFER_BITS - 1);

    state_t     state, state_nx;
    logic [7:0] div_cnt, div_nx;
    logic [2:0] bit_cnt, bit_nx;
    logic [7:0] tx, tx_nx;
    logic [7:0] rx_sh, rx_sh_nx;
    logic [7:0] rx, rx_nx;
    logic       sck_nx, mosi_nx;
    logic       ovr, ovr_nx;
    logic       cs_assert, cs_nx;
    logic       wr_data, div_done;
    logic       unused_wd;

    assign unused_wd = ^wd[15:8];
    assign wr_data   = io_wr & sel_data;
    assign div_done  = (div_cnt == DIV_LAST);
    assign busy      = (state != IDLE);
    assign cs_n      = ~cs_assert;

    assign rd_data = (sel_data ? {8'd0, rx} : 16'd0)
                   | (sel_ctrl ? {13'd0, ovr, cs_assert, busy} : 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx_sh     <= '0;
            rx        <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            ovr       <= 1'b0;
            cs_assert <= 1'b0;
        end else begin
            state     <= state_nx;
            div_cnt   <= div_nx;
            bit_cnt   <= bit_nx;
            tx        <= tx_nx;
            rx_sh     <= rx_sh_nx;
            rx        <= rx_nx;
            sck       <= sck_nx;
            mosi      <= mosi_nx;
            ovr       <= ovr_nx;
            cs_assert <= cs_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        tx_nx    = tx;
        rx_sh_nx = rx_sh;
        rx_nx    = rx;
        sck_nx   = sck;
        mosi_nx  = mosi;
        cs_nx    = (io_wr & sel_ctrl) ? wd[0] : cs_assert;

        // A data write that lands mid-transfer sets overrun even if a status read clears it
        ovr_nx = ovr;
        if (io_rd & sel_ctrl)
            ovr_nx = 1'b0;
        if (wr_data && state != IDLE)
            ovr_nx = 1'b1;

        case (state)
            IDLE: begin
                div_nx = '0;
                if (wr_data) begin
                    state_nx = LOW;
                    sck_nx   = 1'b0;
                    mosi_nx  = wd[7];
                    tx_nx    = wd[7:0];
                    bit_nx   = '0;
                end
            end
            LOW: begin
                if (div_done) begin
                    div_nx   = '0;
                    state_nx = HIGH;
                    sck_nx   = 1'b1;
                    rx_sh_nx = {rx_sh[6:0], miso};
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (div_done) begin
                    div_nx = '0;
                    sck_nx = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = IDLE;
                        rx_nx    = rx_sh;
                    end else begin
                        state_nx = LOW;
                        bit_nx   = bit_cnt + 3'd1;
                        tx_nx    = {tx[6:0], 1'b0};
                        mosi_nx  = tx[6];
                    end
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                div_nx   = '0;
            end
        endcase
    end

endmodule
